// File: rtl/frame_update_scheduler_if.sv
// ---------------------------------------------------------------------------
// frame_update_scheduler_if
// Bundles every non-clock/reset signal of the frame update scheduler:
//   control    : frame_start_i, clear_req_i, draw_req_i
//   drawer     : draw_cell_i, draw_wr_en_i, draw_wr_address_i, draw_en_o
//   sim engine : sim_wr_en_i, sim_wr_address_i, sim_wr_data_i, sim_done_i,
//                sim_start_o
//   RAM port   : ram_wr_en_o, ram_wr_address_o, ram_wr_data_o
//   status     : busy_o, frame_overrun_o, sim_timeout_o
// Modports:
//   slave  - the scheduler itself (consumes *_i, drives *_o)
//   master - the surrounding system (drives *_i, observes *_o)
// ---------------------------------------------------------------------------
interface frame_update_scheduler_if #(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned CELL_BITS = 2
);
    // control
    logic                 frame_start_i;
    logic                 clear_req_i;
    logic                 draw_req_i;

    // mouse drawer
    logic [CELL_BITS-1:0] draw_cell_i;
    logic                 draw_wr_en_i;
    logic [ADDR_W-1:0]    draw_wr_address_i;
    logic                 draw_en_o;

    // simulation engine
    logic                 sim_wr_en_i;
    logic [ADDR_W-1:0]    sim_wr_address_i;
    logic [CELL_BITS-1:0] sim_wr_data_i;
    logic                 sim_done_i;
    logic                 sim_start_o;

    // frame-buffer RAM write port
    logic                 ram_wr_en_o;
    logic [ADDR_W-1:0]    ram_wr_address_o;
    logic [CELL_BITS-1:0] ram_wr_data_o;

    // status
    logic                 busy_o;
    logic                 frame_overrun_o;
    logic                 sim_timeout_o;

    modport slave (
        input  frame_start_i, clear_req_i, draw_req_i,
        input  draw_cell_i, draw_wr_en_i, draw_wr_address_i,
        input  sim_wr_en_i, sim_wr_address_i, sim_wr_data_i, sim_done_i,
        output draw_en_o, sim_start_o,
        output ram_wr_en_o, ram_wr_address_o, ram_wr_data_o,
        output busy_o, frame_overrun_o, sim_timeout_o
    );

    modport master (
        output frame_start_i, clear_req_i, draw_req_i,
        output draw_cell_i, draw_wr_en_i, draw_wr_address_i,
        output sim_wr_en_i, sim_wr_address_i, sim_wr_data_i, sim_done_i,
        input  draw_en_o, sim_start_o,
        input  ram_wr_en_o, ram_wr_address_o, ram_wr_data_o,
        input  busy_o, frame_overrun_o, sim_timeout_o
    );
endinterface

// File: rtl/frame_update_scheduler.sv
// ---------------------------------------------------------------------------
// frame_update_scheduler
// Per-frame phase sequencer and sole owner of the sand frame-buffer write
// port. Each frame tick runs: optional full-screen clear, optional mouse
// draw pass, then one physics-simulation pass. The active requester is
// muxed straight through to the RAM write port; non-owners are dropped.
//
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset
//   bus      - frame_update_scheduler_if.slave (control, drawer, sim engine,
//              RAM write port and status flags)
// ---------------------------------------------------------------------------
module frame_update_scheduler #(
    parameter int unsigned COLUMNS     = 640,
    parameter int unsigned ROWS        = 480,
    parameter int unsigned CELL_BITS   = 2,
    parameter int unsigned CLEAR_VALUE = 0,
    parameter int unsigned SIM_TIMEOUT = 400000
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    frame_update_scheduler_if.slave  bus
);

    localparam int unsigned N_CELLS = COLUMNS * ROWS;
    localparam int unsigned ADDR_W  = $clog2(N_CELLS);
    localparam int unsigned WD_W    = (SIM_TIMEOUT > 1) ? $clog2(SIM_TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0]    PHASE_LAST = ADDR_W'(N_CELLS - 1);
    localparam logic [WD_W-1:0]      WD_LAST    = WD_W'(SIM_TIMEOUT - 1);
    localparam logic [CELL_BITS-1:0] CLEAR_CELL = CELL_BITS'(CLEAR_VALUE);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_SIM   = 2'd3;

    logic [1:0]        state_q,         state_d;
    logic [ADDR_W-1:0] phase_q,         phase_d;
    logic [WD_W-1:0]   wd_q,            wd_d;
    logic              clear_pending_q, clear_pending_d;
    logic              overrun_q,       overrun_d;
    logic              timeout_q,       timeout_d;

    // Write-port mux and strobes are decoded from state so that the drawer
    // and sim engine see zero-latency pass-through onto the RAM.
    logic                 ram_wr_en_c;
    logic [ADDR_W-1:0]    ram_wr_address_c;
    logic [CELL_BITS-1:0] ram_wr_data_c;
    logic                 draw_en_c;
    logic                 sim_start_c;
    logic                 busy_c;

    // State and bookkeeping registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= S_IDLE;
            phase_q         <= '0;
            wd_q            <= '0;
            clear_pending_q <= 1'b0;
            overrun_q       <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            wd_q            <= wd_d;
            clear_pending_q <= clear_pending_d;
            overrun_q       <= overrun_d;
            timeout_q       <= timeout_d;
        end
    end

    // Next-state, counters and write-port mux
    always_comb begin
        state_d          = state_q;
        phase_d          = phase_q;
        wd_d             = wd_q;
        clear_pending_d  = clear_pending_q | bus.clear_req_i;
        overrun_d        = overrun_q | (bus.frame_start_i & (state_q != S_IDLE));
        timeout_d        = timeout_q;

        ram_wr_en_c      = 1'b0;
        ram_wr_address_c = '0;
        ram_wr_data_c    = '0;
        draw_en_c        = 1'b0;
        sim_start_c      = 1'b0;
        busy_c           = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                wd_d    = '0;
                if (bus.frame_start_i) begin
                    if (clear_pending_q || bus.clear_req_i) begin
                        // Entering CLEAR consumes any request seen so far,
                        // including one arriving this very cycle.
                        state_d         = S_CLEAR;
                        clear_pending_d = 1'b0;
                    end else if (bus.draw_req_i) begin
                        state_d = S_DRAW;
                    end else begin
                        state_d = S_SIM;
                    end
                end
            end

            S_CLEAR: begin
                ram_wr_en_c      = 1'b1;
                ram_wr_address_c = phase_q;
                ram_wr_data_c    = CLEAR_CELL;
                if (phase_q == PHASE_LAST) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + ADDR_W'(1);
                end
            end

            S_DRAW: begin
                draw_en_c        = 1'b1;
                ram_wr_en_c      = bus.draw_wr_en_i;
                ram_wr_address_c = bus.draw_wr_address_i;
                ram_wr_data_c    = bus.draw_cell_i;
                // Fixed-length pass; draw_req_i is not looked at here.
                if (phase_q == PHASE_LAST) begin
                    state_d = S_SIM;
                    phase_d = '0;
                    wd_d    = '0;
                end else begin
                    phase_d = phase_q + ADDR_W'(1);
                end
            end

            S_SIM: begin
                // Watchdog is zero only on the first SIM cycle.
                sim_start_c      = (wd_q == '0);
                ram_wr_en_c      = bus.sim_wr_en_i;
                ram_wr_address_c = bus.sim_wr_address_i;
                ram_wr_data_c    = bus.sim_wr_data_i;
                if (bus.sim_done_i) begin
                    // Done wins over a coincident watchdog expiry.
                    state_d = S_IDLE;
                    wd_d    = '0;
                end else if (wd_q == WD_LAST) begin
                    state_d   = S_IDLE;
                    wd_d      = '0;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                phase_d = '0;
                wd_d    = '0;
            end
        endcase
    end

    assign bus.ram_wr_en_o      = ram_wr_en_c;
    assign bus.ram_wr_address_o = ram_wr_address_c;
    assign bus.ram_wr_data_o    = ram_wr_data_c;
    assign bus.draw_en_o        = draw_en_c;
    assign bus.sim_start_o      = sim_start_c;
    assign bus.busy_o           = busy_c;
    assign bus.frame_overrun_o  = overrun_q;
    assign bus.sim_timeout_o    = timeout_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_update_scheduler
// Directed bench for frame_update_scheduler on an 8x4 screen with a
// 100-cycle sim watchdog. Inputs change 1 time unit after each rising edge;
// outputs are sampled 3 units later, mid-cycle.
// ---------------------------------------------------------------------------
module tb_frame_update_scheduler;

    localparam int unsigned COLS   = 8;
    localparam int unsigned ROWS_P = 4;
    localparam int unsigned NC     = COLS * ROWS_P;
    localparam int unsigned AW     = $clog2(NC);
    localparam int unsigned CB     = 2;
    localparam int unsigned TMO    = 100;

    logic clk_i;
    logic reset_i;

    int total;
    int bad;

    frame_update_scheduler_if #(.ADDR_W(AW), .CELL_BITS(CB)) bus ();

    frame_update_scheduler #(
        .COLUMNS    (COLS),
        .ROWS       (ROWS_P),
        .CELL_BITS  (CB),
        .CLEAR_VALUE(0),
        .SIM_TIMEOUT(TMO)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // let combinational outputs settle before sampling
    task automatic settle();
        #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.frame_start_i     = 1'b0;
        bus.clear_req_i       = 1'b0;
        bus.draw_cell_i       = '0;
        bus.draw_wr_en_i      = 1'b0;
        bus.draw_wr_address_i = '0;
        bus.sim_wr_en_i       = 1'b0;
        bus.sim_wr_address_i  = '0;
        bus.sim_wr_data_i     = '0;
        bus.sim_done_i        = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_i = 1'b1;
        bus.draw_req_i = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        reset_i = 1'b0;
        settle();

        // ---- reset state
        chk("rst_busy",    32'(bus.busy_o), 0);
        chk("rst_wr_en",   32'(bus.ram_wr_en_o), 0);
        chk("rst_draw_en", 32'(bus.draw_en_o), 0);
        chk("rst_start",   32'(bus.sim_start_o), 0);
        chk("rst_ovr",     32'(bus.frame_overrun_o), 0);
        chk("rst_tmo",     32'(bus.sim_timeout_o), 0);

        // ---- clear request, then frame tick: 32 writes of 0 at 0..31
        cyc();
        bus.clear_req_i = 1'b1;
        cyc();
        bus.clear_req_i   = 1'b0;
        bus.frame_start_i = 1'b1;
        cyc();
        bus.frame_start_i = 1'b0;
        for (int i = 0; i < int'(NC); i++) begin
            settle();
            chk("clr_wr_en", 32'(bus.ram_wr_en_o), 1);
            chk("clr_addr",  32'(bus.ram_wr_address_o), 32'(i));
            chk("clr_data",  32'(bus.ram_wr_data_o), 0);
            chk("clr_start", 32'(bus.sim_start_o), 0);
            chk("clr_busy",  32'(bus.busy_o), 1);
            cyc();
        end
        settle();
        chk("clr_end_busy",  32'(bus.busy_o), 0);
        chk("clr_end_wr_en", 32'(bus.ram_wr_en_o), 0);
        chk("clr_end_start", 32'(bus.sim_start_o), 0);

        // ---- draw pass: 32 cycles, pass-through, overrun on frame tick
        cyc();
        bus.draw_req_i    = 1'b1;
        bus.frame_start_i = 1'b1;
        cyc();
        bus.frame_start_i = 1'b0;
        for (int i = 0; i < int'(NC); i++) begin
            bus.draw_req_i        = (i < 5);
            bus.frame_start_i     = (i == 10);
            bus.draw_wr_en_i      = (i == 3);
            bus.draw_wr_address_i = AW'(9);
            bus.draw_cell_i       = CB'(2);
            bus.sim_wr_en_i       = (i == 20);
            bus.sim_wr_address_i  = AW'(7);
            settle();
            chk("drw_en",    32'(bus.draw_en_o), 1);
            chk("drw_start", 32'(bus.sim_start_o), 0);
            if (i == 3) begin
                chk("drw_wr_en", 32'(bus.ram_wr_en_o), 1);
                chk("drw_addr",  32'(bus.ram_wr_address_o), 9);
                chk("drw_data",  32'(bus.ram_wr_data_o), 2);
            end
            if (i == 20) chk("drw_sim_drop", 32'(bus.ram_wr_en_o), 0);
            if (i == 11) chk("drw_ovr", 32'(bus.frame_overrun_o), 1);
            cyc();
        end
        idle_inputs();
        bus.draw_req_i = 1'b0;
        settle();
        chk("drw_sim_start", 32'(bus.sim_start_o), 1);
        chk("drw_sim_den",   32'(bus.draw_en_o), 0);
        chk("drw_sim_busy",  32'(bus.busy_o), 1);
        cyc();
        settle();
        chk("drw_sim_start1", 32'(bus.sim_start_o), 0);
        cyc();
        bus.sim_done_i = 1'b1;
        cyc();
        bus.sim_done_i = 1'b0;
        settle();
        chk("drw_sim_idle", 32'(bus.busy_o), 0);

        // ---- straight to SIM, done after 10 cycles
        cyc();
        bus.frame_start_i = 1'b1;
        cyc();
        bus.frame_start_i    = 1'b0;
        bus.sim_wr_en_i      = 1'b1;
        bus.sim_wr_address_i = AW'(5);
        bus.sim_wr_data_i    = CB'(1);
        settle();
        chk("sim_start", 32'(bus.sim_start_o), 1);
        chk("sim_den",   32'(bus.draw_en_o), 0);
        chk("sim_wr_en", 32'(bus.ram_wr_en_o), 1);
        chk("sim_addr",  32'(bus.ram_wr_address_o), 5);
        chk("sim_data",  32'(bus.ram_wr_data_o), 1);
        for (int i = 1; i < 10; i++) begin
            cyc();
            bus.sim_wr_en_i = 1'b0;
            bus.sim_done_i  = (i == 9);
            settle();
            chk("sim_run_busy",  32'(bus.busy_o), 1);
            chk("sim_run_start", 32'(bus.sim_start_o), 0);
        end
        cyc();
        bus.sim_done_i = 1'b0;
        settle();
        chk("sim_idle_busy", 32'(bus.busy_o), 0);
        chk("sim_idle_tmo",  32'(bus.sim_timeout_o), 0);

        // ---- stray sim_done in IDLE is ignored
        bus.sim_done_i = 1'b1;
        cyc();
        bus.sim_done_i = 1'b0;
        settle();
        chk("stray_done_busy", 32'(bus.busy_o), 0);

        // ---- done coincident with watchdog expiry: no timeout flag
        bus.frame_start_i = 1'b1;
        cyc();
        bus.frame_start_i = 1'b0;
        for (int i = 0; i < int'(TMO); i++) begin
            bus.sim_done_i = (i == int'(TMO) - 1);
            settle();
            if (i == int'(TMO) - 1) chk("tie_busy", 32'(bus.busy_o), 1);
            cyc();
        end
        bus.sim_done_i = 1'b0;
        settle();
        chk("tie_idle", 32'(bus.busy_o), 0);
        chk("tie_tmo",  32'(bus.sim_timeout_o), 0);

        // ---- watchdog expiry with no done
        bus.frame_start_i = 1'b1;
        cyc();
        bus.frame_start_i = 1'b0;
        for (int i = 0; i < int'(TMO); i++) begin
            settle();
            if (i == int'(TMO) - 1) begin
                chk("wd_last_busy", 32'(bus.busy_o), 1);
                chk("wd_last_tmo",  32'(bus.sim_timeout_o), 0);
            end
            cyc();
        end
        settle();
        chk("wd_idle", 32'(bus.busy_o), 0);
        chk("wd_tmo",  32'(bus.sim_timeout_o), 1);
        bus.sim_wr_en_i = 1'b1;
        settle();
        chk("wd_stray_wr", 32'(bus.ram_wr_en_o), 0);
        bus.sim_wr_en_i = 1'b0;

        // ---- clear with a second request arriving mid-clear
        cyc();
        bus.clear_req_i   = 1'b1;
        bus.frame_start_i = 1'b1;
        cyc();
        bus.clear_req_i   = 1'b0;
        bus.frame_start_i = 1'b0;
        for (int i = 0; i < int'(NC); i++) begin
            bus.clear_req_i = (i == 4);
            settle();
            if (i == 0) chk("clr2_addr0", 32'(bus.ram_wr_address_o), 0);
            cyc();
        end
        bus.clear_req_i = 1'b0;
        settle();
        chk("clr2_idle", 32'(bus.busy_o), 0);

        // pending clear must beat draw_req on the next tick
        bus.draw_req_i    = 1'b1;
        bus.frame_start_i = 1'b1;
        cyc();
        bus.frame_start_i = 1'b0;
        bus.draw_req_i    = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            bus.clear_req_i = (i == 5);
            settle();
            if (i == 0) begin
                chk("clr3_wr_en", 32'(bus.ram_wr_en_o), 1);
                chk("clr3_den",   32'(bus.draw_en_o), 0);
            end
            if (i == 12) chk("clr3_addr12", 32'(bus.ram_wr_address_o), 12);
            if (i < 12) cyc();
        end
        bus.clear_req_i = 1'b0;

        // ---- reset while writing address 12
        reset_i = 1'b1;
        cyc();
        settle();
        chk("mrst_wr_en", 32'(bus.ram_wr_en_o), 0);
        chk("mrst_busy",  32'(bus.busy_o), 0);
        chk("mrst_ovr",   32'(bus.frame_overrun_o), 0);
        chk("mrst_tmo",   32'(bus.sim_timeout_o), 0);
        reset_i = 1'b0;
        cyc();

        // pending clear was dropped by reset: tick goes straight to SIM
        bus.frame_start_i = 1'b1;
        cyc();
        bus.frame_start_i = 1'b0;
        settle();
        chk("post_rst_start", 32'(bus.sim_start_o), 1);
        chk("post_rst_wr_en", 32'(bus.ram_wr_en_o), 0);
        bus.sim_done_i = 1'b1;
        cyc();
        bus.sim_done_i = 1'b0;
        settle();
        chk("post_rst_idle", 32'(bus.busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL global_timeout observed=stalled expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frame_update_scheduler.md
Name: frame_update_scheduler

Overview:
Per-frame scheduler and owner of the single write port of the sand frame-buffer RAM. On each frame tick it runs one phase sequence: optional full-screen clear, optional mouse-draw pass, then one physics-simulation pass. It gates the mouse pixel drawer via draw_en_o, starts and times the simulation engine, and muxes the active requester onto the RAM write port. It sits between the mouse drawer, the sand physics engine and the frame-buffer RAM.

Parameters:
COLUMNS, 640, screen width in cells
ROWS, 480, screen height in cells
CELL_BITS, 2, bits per cell value written to RAM
CLEAR_VALUE, 0, cell value written during clear (empty cell)
SIM_TIMEOUT, 400000, max cycles allowed in SIM before forced abort

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
frame_start_i  in  1  one-cycle pulse at start of vertical blank
clear_req_i  in  1  one-cycle pulse requesting a screen clear
draw_req_i  in  1  level; mouse button held
draw_cell_i  in  CELL_BITS  cell type placed by the mouse
draw_wr_en_i  in  1  drawer write enable
draw_wr_address_i  in  $clog2(COLUMNS*ROWS)  drawer write address
sim_wr_en_i  in  1  sim engine write enable
sim_wr_address_i  in  $clog2(COLUMNS*ROWS)  sim engine write address
sim_wr_data_i  in  CELL_BITS  sim engine write data
sim_done_i  in  1  one-cycle pulse: sim pass finished
draw_en_o  out  1  enables mouse drawer scan
sim_start_o  out  1  one-cycle pulse starting sim pass
ram_wr_en_o  out  1  RAM write enable
ram_wr_address_o  out  $clog2(COLUMNS*ROWS)  RAM write address
ram_wr_data_o  out  CELL_BITS  RAM write data
busy_o  out  1  high whenever state != IDLE
frame_overrun_o  out  1  sticky: frame_start_i seen while busy
sim_timeout_o  out  1  sticky: SIM aborted by watchdog

Behaviour:
- Reset (sync): state IDLE, all outputs 0, clear_pending 0, phase counter 0, watchdog 0, sticky flags cleared. Reset mid-phase aborts immediately; no further RAM writes.
- N = COLUMNS*ROWS; phase counter is $clog2(N) bits, never exceeds N-1.
- clear_pending: set by clear_req_i in any state; cleared on entry to CLEAR. Request during CLEAR stays pending for next frame.
- IDLE: on frame_start_i -> CLEAR if clear_pending (or clear_req_i same cycle), else DRAW if draw_req_i, else SIM.
- CLEAR: ram_wr_en_o=1 every cycle, address = phase counter 0..N-1, data = CLEAR_VALUE; exactly N writes. After address N-1 -> IDLE (no draw/sim that frame).
- DRAW: draw_en_o=1; RAM port = drawer inputs, data = draw_cell_i, combinational (zero-latency) pass-through. Lasts exactly N cycles counted by phase counter; then -> SIM. draw_req_i sampled only in IDLE; release mid-pass does not shorten the pass.
- SIM: sim_start_o=1 on first SIM cycle only; RAM port = sim inputs, pass-through. sim_done_i -> IDLE. Watchdog counts SIM cycles; reaching SIM_TIMEOUT with no done -> set sim_timeout_o, -> IDLE. sim_done_i in the same cycle as timeout: treated as done, flag not set. sim_done_i outside SIM ignored.
- Non-owners never reach RAM: in IDLE ram_wr_en_o=0; drawer write enables outside DRAW and sim enables outside SIM are dropped.
- frame_start_i while busy_o=1: ignored, frame_overrun_o set. Flags clear only on reset.
- Phase counter and watchdog reset to 0 on every state entry.

Test Plan:
- COLUMNS=8, ROWS=4: clear_req_i then frame_start_i -> 32 consecutive writes, addresses 0..31, data 0, busy_o drops cycle after address 31; no sim_start_o.
- draw_req_i=1, frame_start_i -> draw_en_o high exactly 32 cycles, drawer writes (address 9, wr_en) appear same cycle on RAM port with draw_cell_i=2; then one sim_start_o pulse.
- draw_req_i=0, frame_start_i -> straight to SIM; sim writes addr 5 data 1 pass through; sim_done_i after 10 cycles -> IDLE, busy_o=0.
- SIM_TIMEOUT=100, no sim_done_i -> SIM exits after 100 cycles, sim_timeout_o=1; stray sim_wr_en_i afterward produces no ram_wr_en_o.
- frame_start_i during DRAW -> ignored, frame_overrun_o=1, sequence unaffected; clear_req_i during CLEAR -> next frame clears again.
- reset_i asserted mid-CLEAR at address 12 -> next cycle ram_wr_en_o=0, busy_o=0, flags 0, clear_pending 0.
